circuit_result_reader: RTL and testbench

//  Consumer end of the circuit result interface. Captures W-bit results
//  (x_in, strobed by en) into a DEPTH-entry FIFO and streams each word out as
//  W/OW narrow beats over a valid/ready handshake, least-significant beat first.

---
 rtl/circuit_result_reader_pkg.sv | 28 ++
 rtl/circuit_result_reader_fifo.sv | 49 ++++
 rtl/circuit_result_reader.sv | 112 +++++++++++
 tb/tb_circuit_result_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/circuit_result_reader_pkg.sv
// Shared definitions for the circuit result reader: FSM encoding, beat math
// and the word/beat width-compatibility check.
`ifndef CIRCUIT_RESULT_READER_PKG_SV
`define CIRCUIT_RESULT_READER_PKG_SV

`define CRR_WIDTH_OK(w, ow) ((((w) % (ow)) == 0))

package circuit_result_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } rd_state_e;

    // Number of OW-bit beats that make up one W-bit word.
    function automatic int beats_of(input int w, input int ow);
        return w / ow;
    endfunction

    // Counter width able to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/circuit_result_reader_fifo.sv
// Synchronous DEPTH x W result FIFO; full/empty derive from registered
// pointers only, so a same-edge pop never frees a slot for that edge's push.
module result_fifo
    import circuit_result_reader_pkg::*;
#(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = idx_width(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/circuit_result_reader.sv
// Consumer end of the circuit result interface: buffers W-bit results and
// streams each one out as W/OW beats, least-significant beat first.
module circuit_result_reader
    import circuit_result_reader_pkg::*;
#(
    parameter int W     = 96,
    parameter int OW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  x_in,
    output logic          in_ready,
    output logic [OW-1:0] o_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_last,
    output logic          ovf,
    output logic [15:0]   words_out
);
    localparam int BEATS = beats_of(W, OW);
    localparam int BW    = idx_width(BEATS);

    if (!`CRR_WIDTH_OK(W, OW)) begin : g_width_check
        $error("circuit_result_reader: W must be a multiple of OW");
    end

    rd_state_e     state_q, state_d;
    logic [W-1:0]  shreg_q;
    logic [BW-1:0] beat_q;
    logic [15:0]   words_q;
    logic          ovf_q;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W-1:0]  fifo_head;
    logic          last_beat;
    logic          xfer;

    result_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (en),
        .push_data (x_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign xfer      = (state_q == ST_SEND) && o_ready;

    assign in_ready  = !fifo_full;
    assign o_valid   = (state_q == ST_SEND);
    assign o_data    = (state_q == ST_SEND) ? shreg_q[OW-1:0] : '0;
    assign o_last    = (state_q == ST_SEND) && last_beat;
    assign ovf       = ovf_q;
    assign words_out = words_q;

    // NOTE: defaults first so every path assigns every output (no latches).
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD: begin
                fifo_pop = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (xfer && last_beat) begin
                    // Chain straight into the next word to avoid a bubble.
                    if (!fifo_empty) fifo_pop = 1'b1;
                    else             state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (en && fifo_full) ovf_q <= 1'b1;
            if (state_q == ST_LOAD) begin
                shreg_q <= fifo_head;
                beat_q  <= '0;
            end else if (xfer) begin
                if (last_beat) begin
                    words_q <= words_q + 16'd1;
                    if (!fifo_empty) begin
                        shreg_q <= fifo_head;
                        beat_q  <= '0;
                    end
                end else begin
                    shreg_q <= shreg_q >> OW;
                    beat_q  <= beat_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_circuit_result_reader.sv
// Self-checking bench for circuit_result_reader: directed scenarios plus
// random traffic, compared each cycle against a queue-based reference model.
module tb_circuit_result_reader;

    localparam int W     = 96;
    localparam int OW    = 32;
    localparam int DEPTH = 4;
    localparam int BEATS = W / OW;

    logic          clk = 1'b0;
    logic          clk_en = 1'b1;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  x_in = '0;
    logic          in_ready;
    logic [OW-1:0] o_data;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic          o_last;
    logic          ovf;
    logic [15:0]   words_out;

    int passed = 0;
    int total  = 0;

    circuit_result_reader #(.W(W), .OW(OW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .x_in      (x_in),
        .in_ready  (in_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_last    (o_last),
        .ovf       (ovf),
        .words_out (words_out)
    );

    initial forever #5 clk = clk_en ? ~clk : clk;

    // Reference model: words waiting in the buffer, the word being sent,
    // and the phase of the reader (0 idle, 1 fetching, 2 sending).
    logic [W-1:0] m_fq[$];
    logic [W-1:0] m_cur;
    int           m_beat;
    int           m_phase;
    logic [15:0]  m_words;
    logic         m_ovf;

    task automatic m_reset();
        m_fq.delete();
        m_cur   = '0;
        m_beat  = 0;
        m_phase = 0;
        m_words = '0;
        m_ovf   = 1'b0;
    endtask

    task automatic m_step(input logic e, input logic [W-1:0] x, input logic r);
        bit was_full = (m_fq.size() == DEPTH);
        case (m_phase)
            0: if (m_fq.size() > 0) m_phase = 1;
            1: begin
                m_cur   = m_fq.pop_front();
                m_beat  = 0;
                m_phase = 2;
            end
            default: if (r) begin
                if (m_beat == BEATS - 1) begin
                    m_words = m_words + 16'd1;
                    if (m_fq.size() > 0) begin
                        m_cur  = m_fq.pop_front();
                        m_beat = 0;
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_beat++;
                end
            end
        endcase
        if (e && was_full) m_ovf = 1'b1;
        if (e && !was_full) m_fq.push_back(x);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        logic          e_valid = (m_phase == 2);
        logic [OW-1:0] e_data  = e_valid ? m_cur[m_beat*OW +: OW] : '0;
        check("o_valid",   W'(o_valid),   W'(e_valid));
        check("o_data",    W'(o_data),    W'(e_data));
        check("o_last",    W'(o_last),    W'(e_valid && (m_beat == BEATS - 1)));
        check("in_ready",  W'(in_ready),  W'(m_fq.size() < DEPTH));
        check("ovf",       W'(ovf),       W'(m_ovf));
        check("words_out", W'(words_out), W'(m_words));
    endtask

    // One clock: drive at negedge, check, advance model on posedge.
    task automatic tick(input logic e, input logic [W-1:0] x, input logic r);
        en = e; x_in = x; o_ready = r;
        #1;
        check_outputs();
        @(posedge clk);
        m_step(e, x, r);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    logic [W-1:0] w123;
    bit           saw_not_ready;
    int           valid_run;

    initial begin
        w123 = 96'h000000030000000200000001;
        m_reset();

        // Reset held for three cycles, then released away from the edge.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tick(1'b0, '0, 1'b0);
        check("reset_in_ready", W'(in_ready), W'(1'b1));

        // Single word with free-flowing output.
        tick(1'b1, w123, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b1);
        check("single_words", W'(words_out), W'(16'd1));

        // Backpressure: stall until presented, then o_ready 1,0,0,1,1.
        tick(1'b1, w123, 1'b0);
        repeat (2) tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b1);
        check("bp_words", W'(words_out), W'(16'd2));

        // Overflow: six strobes against a stalled output.
        saw_not_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, rand_word(), 1'b0);
            if (!in_ready) saw_not_ready = 1'b1;
        end
        check("ovf_in_ready_low", W'(saw_not_ready), W'(1'b1));
        check("ovf_sticky", W'(ovf), W'(1'b1));
        repeat (20) tick(1'b0, '0, 1'b1);

        // Back-to-back: three words, nine contiguous valid beats.
        m_words = m_words; // model keeps counting from the current total
        for (int i = 0; i < 3; i++) tick(1'b1, rand_word(), 1'b1);
        valid_run = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_valid) valid_run++;
            tick(1'b0, '0, 1'b1);
        end
        check("b2b_valid_run", W'(valid_run), W'(32'd9));

        // Random traffic.
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 9) < 4, rand_word(), $urandom_range(0, 9) < 7);
        repeat (20) tick(1'b0, '0, 1'b1);

        // Async reset mid-beat with the clock stopped.
        tick(1'b1, rand_word(), 1'b0);
        repeat (2) tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        check("pre_reset_valid", W'(o_valid), W'(1'b1));
        clk_en = 1'b0;
        #7;
        rst = 1'b0;
        #1;
        check("async_rst_valid", W'(o_valid), W'(1'b0));
        check("async_rst_data",  W'(o_data),  W'(0));
        check("async_rst_words", W'(words_out), W'(0));
        m_reset();
        #10;
        rst = 1'b1;
        #3;
        clk_en = 1'b1;
        @(negedge clk);
        repeat (5) tick(1'b0, '0, 1'b1);
        tick(1'b1, w123, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
